display_scan_mux: RTL and testbench

//  - Upstream feeder for the 7-segment nibble decoder on the parking-slot display.
//  - Takes a 4-digit hex value (slot count and status) and time-multiplexes it onto one shared decoder plus 4 anodes.
//  - Latches the value once per frame so the display never tears, and inserts anode dead-time between digits against ghosting.
//  - Optional leading-zero blanking: emits nibble 4'hF, which the decoder renders as all segments off.

---
 rtl/display_scan_mux_pkg.sv | 33 +++
 rtl/display_scan_mux_if.sv | 15 +
 rtl/display_scan_mux_scan_prescaler.sv | 69 ++++++
 rtl/display_scan_mux.sv | 78 +++++++
 tb/tb_display_scan_mux.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/display_scan_mux_pkg.sv
// Shared definitions for the parking-slot display path: digit count,
// blank codes, the scan sequencer state type and the nibble/blanking helpers.
package display_pkg;

    localparam int          N_DIGITS     = 4;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
    localparam logic [3:0]  AN_ALL_OFF   = 4'hF;

    typedef logic [1:0] digit_idx_t;

    // ARMED: the next enabled edge latches a fresh frame; RUN: scanning.
    typedef enum logic {
        SCAN_ARMED = 1'b0,
        SCAN_RUN   = 1'b1
    } scan_state_t;

    // Nibble shown in slot idx of a 4-digit word.
    function automatic logic [3:0] nibble_of(input logic [15:0] v, input digit_idx_t idx);
        logic [15:0] sh;
        sh = v >> {idx, 2'b00};
        return sh[3:0];
    endfunction

    // A digit is a leading zero when it and every digit to its left are zero.
    // Digit 0 is always shown so a zero value still reads "0".
    function automatic logic lead_zero_blank(input logic [15:0] v, input digit_idx_t idx,
                                             input logic lzb);
        logic [15:0] upper;
        upper = v >> {idx, 2'b00};
        return lzb && (idx != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Control and display signals between the value source and the scan mux.
interface display_scan_mux_if;
    import display_pkg::*;

    logic                en;
    logic [15:0]         value;
    logic                lzb_en;
    logic [3:0]          digit;
    logic [N_DIGITS-1:0] an;
    logic                frame_tick;

    modport master (output en, value, lzb_en, input digit, an, frame_tick);
    modport slave  (input en, value, lzb_en, output digit, an, frame_tick);

endinterface

// File: rtl/display_scan_mux_scan_prescaler.sv
// Slot timer and digit index for the scan mux. cnt runs through one digit
// slot, idx steps through the four digits, and an armed state makes the
// first enabled edge after reset or en rising start a fresh frame.
module scan_prescaler
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    output digit_idx_t idx_o,
    output logic       slot_wrap_o,
    output logic       frame_start_o,
    output logic       in_blank_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;

    // Sequencer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN_ARMED;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next slot position; dropping en parks the scan at the start and re-arms.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        slot_wrap_o   = 1'b0;
        frame_start_o = 1'b0;
        if (!en_i) begin
            state_d = SCAN_ARMED;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (state_q == SCAN_ARMED) begin
            state_d       = SCAN_RUN;
            cnt_d         = '0;
            idx_d         = '0;
            frame_start_o = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d         = '0;
            idx_d         = idx_q + 2'd1;
            slot_wrap_o   = 1'b1;
            frame_start_o = (idx_q == 2'd3);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign idx_o      = idx_q;
    assign in_blank_o = (cnt_q < BLANK_END);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexes a 4-digit hex value onto one shared 7-segment decoder.
// The value is captured once per frame so a scan never mixes two values,
// and each slot opens with all anodes off to suppress ghosting.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic clk,
    input  logic rst,
    display_scan_mux_if.slave bus
);

    digit_idx_t          idx;
    logic                slot_wrap;
    logic                frame_start;
    logic                in_blank;

    logic [15:0]         shadow_q, shadow_d;
    logic [3:0]          digit_q, digit_d;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic                frame_tick_q, frame_tick_d;

    scan_prescaler #(
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_prescaler (
        .clk          (clk),
        .rst          (rst),
        .en_i         (bus.en),
        .idx_o        (idx),
        .slot_wrap_o  (slot_wrap),
        .frame_start_o(frame_start),
        .in_blank_o   (in_blank)
    );

    // Shadow value and output registers; outputs trail the scan state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            digit_q      <= BLANK_NIBBLE;
            an_q         <= AN_ALL_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            digit_q      <= digit_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Frame latch, leading-zero blanking and anode select for the current slot.
    always_comb begin
        shadow_d     = frame_start ? bus.value : shadow_q;
        digit_d      = BLANK_NIBBLE;
        an_d         = AN_ALL_OFF;
        frame_tick_d = 1'b0;
        if (bus.en) begin
            frame_tick_d = frame_start;
            if (!lead_zero_blank(shadow_q, idx, bus.lzb_en)) begin
                digit_d = nibble_of(shadow_q, idx);
            end
            if (!in_blank) begin
                an_d = ~(4'b0001 << idx);
            end
        end
    end

    // A running frame may only begin on the wrap out of the last slot.
    frame_wrap_chk: assert property (@(posedge clk) disable iff (rst)
        (frame_start && idx == 2'd3) |-> slot_wrap);

    assign bus.digit      = digit_q;
    assign bus.an         = an_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios followed by random
// stimulus, compared every cycle against a frame-position reference model.
module tb_display_scan_mux;

    localparam int D  = 8;
    localparam int B  = 2;
    localparam int FR = 4 * D;

    logic clk;
    logic rst;

    display_scan_mux_if bus_if ();

    display_scan_mux #(
        .SCAN_DIV    (D),
        .BLANK_CYCLES(B)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference: position within the frame, value shown this frame, armed flag.
    int          m_pos;
    logic [15:0] m_shadow;
    logic        m_armed;
    logic [3:0]  e_an;
    logic [3:0]  e_dig;
    logic        e_ft;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int          idx;
        int          c;
        logic [15:0] upper;
        if (rst) begin
            m_pos = 0; m_shadow = '0; m_armed = 1'b1;
            e_an = 4'hF; e_dig = 4'hF; e_ft = 1'b0;
        end else if (!bus_if.en) begin
            m_pos = 0; m_armed = 1'b1;
            e_an = 4'hF; e_dig = 4'hF; e_ft = 1'b0;
        end else begin
            idx = m_pos / D;
            c   = m_pos % D;
            e_an = 4'hF;
            if (c >= B) e_an[idx] = 1'b0;
            upper = m_shadow >> (4 * idx);
            if (bus_if.lzb_en && idx != 0 && upper == 16'h0000) e_dig = 4'hF;
            else e_dig = upper[3:0];
            if (m_armed) begin
                m_shadow = bus_if.value;
                m_pos    = 0;
                m_armed  = 1'b0;
                e_ft     = 1'b1;
            end else begin
                m_pos = (m_pos + 1) % FR;
                e_ft  = (m_pos == 0);
                if (m_pos == 0) m_shadow = bus_if.value;
            end
        end
    endtask

    task automatic step();
        logic [3:0] an_low;
        @(posedge clk);
        model_edge();
        #1;
        check("an", 16'(bus_if.an), 16'(e_an));
        check("digit", 16'(bus_if.digit), 16'(e_dig));
        check("frame_tick", 16'(bus_if.frame_tick), 16'(e_ft));
        an_low = ~bus_if.an;
        check("one_anode", 16'($countones(an_low) <= 1), 16'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [15:0] mask;
        m_pos = 0; m_shadow = '0; m_armed = 1'b1;
        e_an = 4'hF; e_dig = 4'hF; e_ft = 1'b0;

        rst = 1'b1;
        bus_if.en = 1'b1;
        bus_if.value = 16'h1234;
        bus_if.lzb_en = 1'b0;
        run(3);
        rst = 1'b0;
        run(2 * FR + 5);

        bus_if.value = 16'h0050; bus_if.lzb_en = 1'b1;
        run(2 * FR);
        bus_if.value = 16'h0000;
        run(2 * FR);
        bus_if.value = 16'h0050; bus_if.lzb_en = 1'b0;
        run(2 * FR);

        bus_if.value = 16'h1234;
        run(FR + 2 * D + 3);
        bus_if.value = 16'hABCD;
        run(2 * FR);

        run(5);
        bus_if.en = 1'b0;
        run(4);
        bus_if.en = 1'b1;
        run(FR + 4);

        run(2 * D + 5);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(FR + 4);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) bus_if.en = ~bus_if.en;
            if ($urandom_range(0, 39) == 0) bus_if.lzb_en = ~bus_if.lzb_en;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 4))
                    0:       mask = 16'hFFFF;
                    1:       mask = 16'h00FF;
                    2:       mask = 16'h000F;
                    3:       mask = 16'h0F0F;
                    default: mask = 16'h0000;
                endcase
                bus_if.value = 16'($urandom) & mask;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
